// File: rtl/frame_update_scheduler_if.sv
// Request/grant/done handshake between the frame update scheduler and the game object updaters.
interface frame_update_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;

  modport master (input req, input done, output grant);
  modport slave  (output req, output done, input grant);
endinterface

// File: rtl/frame_update_scheduler.sv
// Round-robin scheduler that runs per-frame game-logic updates inside vertical blanking.
// Optional build macro UPDATE_WATCHDOG_EN bounds each grant to TIMEOUT_CYCLES cycles.
module frame_update_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ACTIVE_COLS    = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int TOTAL_COLS     = 800,
  parameter int TOTAL_ROWS     = 525,
  parameter int FRAME_DIV      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic [9:0]               i_Col_Count,
  input  logic [9:0]               i_Row_Count,
  input  logic                     i_Clear_Status,
  frame_update_scheduler_if.master upd,
  output logic                     o_Busy,
  output logic                     o_Frame_Tick,
  output logic                     o_Overrun,
  output logic [NUM_REQ-1:0]       o_Timeout,
  output logic [15:0]              o_Frame_Count
);

  localparam int              IDXW      = $clog2(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_REQ - 1);
  localparam logic [9:0]      BLANK_ROW = 10'(ACTIVE_ROWS);
  localparam logic [7:0]      DIV_LAST  = 8'(FRAME_DIV - 1);

  // An illegal parameter set leaves the scheduler permanently idle rather than misbehaving.
  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                          (FRAME_DIV >= 1) && (FRAME_DIV <= 255) &&
                          (ACTIVE_COLS < TOTAL_COLS) && (ACTIVE_ROWS < TOTAL_ROWS) &&
                          (TIMEOUT_CYCLES >= 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_GRANT
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  pending, pending_nxt;
  logic [NUM_REQ-1:0]  grant_q, grant_nxt;
  logic [IDXW-1:0]     rr_ptr, rr_nxt;
  logic [IDXW-1:0]     gidx, gidx_nxt;
  logic                busy_nxt;
  logic                ovr_set;
  logic [7:0]          div_cnt;
  logic                blank_evt;
  logic                start_evt;
  logic                arb_found;
  logic [IDXW-1:0]     arb_idx;

`ifdef UPDATE_WATCHDOG_EN
  localparam int             WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0]      wd_cnt;
  logic                wd_clr;
  logic [NUM_REQ-1:0]  to_set;
`endif

  assign blank_evt = CFG_OK && (i_Row_Count == BLANK_ROW) && (i_Col_Count == 10'd0);
  assign start_evt = CFG_OK && (i_Row_Count == 10'd0) && (i_Col_Count == 10'd0);
  assign upd.grant = grant_q;

  // Pick the first pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDXW'(cand);
      if (!arb_found && pending[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Active video restarting always wins: whatever is in flight is abandoned.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    grant_nxt   = grant_q;
    rr_nxt      = rr_ptr;
    gidx_nxt    = gidx;
    busy_nxt    = o_Busy;
    ovr_set     = 1'b0;
`ifdef UPDATE_WATCHDOG_EN
    wd_clr      = 1'b0;
    to_set      = '0;
`endif
    if (start_evt && (state != S_IDLE)) begin
      state_nxt   = S_IDLE;
      pending_nxt = '0;
      grant_nxt   = '0;
      busy_nxt    = 1'b0;
      ovr_set     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (blank_evt && (div_cnt == 8'd0) && (|upd.req)) begin
            pending_nxt = upd.req;
            state_nxt   = S_ARB;
            busy_nxt    = 1'b1;
          end
        end
        S_ARB: begin
          if (arb_found) begin
            grant_nxt          = '0;
            grant_nxt[arb_idx] = 1'b1;
            gidx_nxt           = arb_idx;
            rr_nxt             = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            state_nxt          = S_GRANT;
`ifdef UPDATE_WATCHDOG_EN
            wd_clr             = 1'b1;
`endif
          end else begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end
        end
        S_GRANT: begin
          if (upd.done[gidx]) begin
            grant_nxt         = '0;
            pending_nxt[gidx] = 1'b0;
            state_nxt         = S_ARB;
          end
`ifdef UPDATE_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            grant_nxt         = '0;
            pending_nxt[gidx] = 1'b0;
            to_set[gidx]      = 1'b1;
            state_nxt         = S_ARB;
          end
`endif
        end
        default: begin
          state_nxt   = S_IDLE;
          pending_nxt = '0;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      pending <= '0;
      grant_q <= '0;
      rr_ptr  <= '0;
      gidx    <= '0;
      o_Busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_nxt;
      gidx    <= gidx_nxt;
      o_Busy  <= busy_nxt;
    end
  end

  // Frame bookkeeping runs on every blank event, even a stray one during a pass.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Frame_Tick  <= 1'b0;
      o_Frame_Count <= 16'd0;
      div_cnt       <= 8'd0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Frame_Tick <= blank_evt;
      if (blank_evt) begin
        o_Frame_Count <= o_Frame_Count + 16'd1;
        div_cnt       <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      end
      o_Overrun <= ovr_set | (o_Overrun & ~i_Clear_Status);
    end
  end

`ifdef UPDATE_WATCHDOG_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_cnt    <= '0;
      o_Timeout <= '0;
    end else begin
      if (wd_clr) begin
        wd_cnt <= '0;
      end else if (state == S_GRANT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      o_Timeout <= to_set | (o_Timeout & {NUM_REQ{~i_Clear_Status}});
    end
  end
`else
  assign o_Timeout = '0;
`endif

endmodule
